// File: rtl/if_id_ctrl.sv
// IF/ID pipeline register owner: latches fetched instructions, injects NOP bubbles, gates the PC write.
// Optional bubble performance counter enabled by defining IF_ID_PERF_CNT_EN.
module if_id_ctrl #(
    parameter int          FLUSH_CYCLES = 1,
    parameter int          MAX_STALL    = 15,
    parameter logic [15:0] NOP_INSTR    = 16'h0800
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] fetch_instr_i,
    input  logic [15:0] fetch_pc_nxt_i,
    input  logic        nop_req_i,
    input  logic        stall_req_i,
    input  logic        flush_req_i,
    output logic        pc_we_o,
    output logic [15:0] id_instr_o,
    output logic [15:0] id_pc_nxt_o,
    output logic        id_valid_o,
    output logic        stall_err_o,
    output logic [15:0] bubble_cnt_o
);

    localparam int SW = $clog2(MAX_STALL + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   instr_q, instr_d;
    logic [15:0]   pc_q, pc_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          pc_we_c;

    always_comb begin
        state_d = state_q;
        instr_d = NOP_INSTR;
        pc_d    = pc_q;
        valid_d = 1'b0;
        err_d   = err_q;
        scnt_d  = scnt_q;
        fcnt_d  = fcnt_q;
        pc_we_c = 1'b1;
        if (flush_req_i) begin
            pc_d   = fetch_pc_nxt_i;
            scnt_d = '0;
            if (FLUSH_CYCLES == 1) begin
                state_d = RUN;
                fcnt_d  = '0;
            end else begin
                state_d = FLUSH;
                fcnt_d  = FW'(FLUSH_CYCLES - 1);
            end
        end else begin
            case (state_q)
                FLUSH: begin
                    // requests other than flush are ignored until the bubble train ends
                    pc_d = fetch_pc_nxt_i;
                    if (fcnt_q <= FW'(1)) begin
                        state_d = RUN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - FW'(1);
                    end
                end
                RUN, STALL: begin
                    if (stall_req_i) begin
                        pc_we_c = 1'b0;
                        state_d = STALL;
                        if (scnt_q == SW'(MAX_STALL)) begin
                            err_d = 1'b1;
                        end else begin
                            scnt_d = scnt_q + SW'(1);
                        end
                    end else begin
                        state_d = RUN;
                        scnt_d  = '0;
                        pc_d    = fetch_pc_nxt_i;
                        if (!nop_req_i) begin
                            instr_d = fetch_instr_i;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    pc_we_c = 1'b0;
                    state_d = RUN;
                end
            endcase
        end
    end

    assign pc_we_o = rst_i ? 1'b0 : pc_we_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            scnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] bcnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bcnt_q <= '0;
        end else if (!valid_d && bcnt_q != 16'hFFFF) begin
            bcnt_q <= bcnt_q + 16'd1;
        end
    end

    assign bubble_cnt_o = bcnt_q;
`else
    assign bubble_cnt_o = 16'h0000;
`endif

    assign id_instr_o  = instr_q;
    assign id_pc_nxt_o = pc_q;
    assign id_valid_o  = valid_q;
    assign stall_err_o = err_q;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed bench for if_id_ctrl (FLUSH_CYCLES=3, MAX_STALL=15); bubble_cnt expectation follows IF_ID_PERF_CNT_EN.
module tb_if_id_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fetch_instr, fetch_pc_nxt;
    logic        nop_req, stall_req, flush_req;
    logic        pc_we;
    logic [15:0] id_instr, id_pc_nxt, bubble_cnt;
    logic        id_valid, stall_err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_bub     = 0;

    if_id_ctrl #(.FLUSH_CYCLES(3), .MAX_STALL(15), .NOP_INSTR(16'h0800)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_instr_i  (fetch_instr),
        .fetch_pc_nxt_i (fetch_pc_nxt),
        .nop_req_i      (nop_req),
        .stall_req_i    (stall_req),
        .flush_req_i    (flush_req),
        .pc_we_o        (pc_we),
        .id_instr_o     (id_instr),
        .id_pc_nxt_o    (id_pc_nxt),
        .id_valid_o     (id_valid),
        .stall_err_o    (stall_err),
        .bubble_cnt_o   (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle away from the edge, check combinational pc_we, then advance past the edge.
    task automatic cyc(input logic [15:0] instr, input logic [15:0] pc, input logic nop,
                       input logic stall, input logic flush, input logic r, input logic exp_we);
        @(negedge clk);
        fetch_instr  = instr;
        fetch_pc_nxt = pc;
        nop_req      = nop;
        stall_req    = stall;
        flush_req    = flush;
        rst          = r;
        #1;
        chk("pc_we", {15'd0, pc_we}, {15'd0, exp_we});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                          input logic ev);
        chk({tag, ".id_instr"}, id_instr, ei);
        chk({tag, ".id_pc_nxt"}, id_pc_nxt, ep);
        chk({tag, ".id_valid"}, {15'd0, id_valid}, {15'd0, ev});
    endtask

    task automatic chk_bub(input string tag);
`ifdef IF_ID_PERF_CNT_EN
        chk({tag, ".bubble_cnt"}, bubble_cnt, 16'(exp_bub));
`else
        chk({tag, ".bubble_cnt"}, bubble_cnt, 16'h0000);
`endif
    endtask

    initial begin
        rst = 1'b1; fetch_instr = '0; fetch_pc_nxt = '0;
        nop_req = 1'b0; stall_req = 1'b0; flush_req = 1'b0;

        cyc(16'h1111, 16'h1112, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(16'h2222, 16'h2224, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_id("reset", 16'h0800, 16'h0000, 1'b0);
        chk("reset.stall_err", {15'd0, stall_err}, 16'h0000);
        chk_bub("reset");

        cyc(16'h4001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_id("run1", 16'h4001, 16'h0002, 1'b1);
        cyc(16'h4002, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_id("run2", 16'h4002, 16'h0004, 1'b1);
        cyc(16'h4003, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_id("run3", 16'h4003, 16'h0006, 1'b1);

        cyc(16'hC123, 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_bub++;
        chk_id("stall1", 16'h0800, 16'h0006, 1'b0);
        cyc(16'hC123, 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_bub++;
        chk_id("stall2", 16'h0800, 16'h0006, 1'b0);
        cyc(16'hC123, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_id("release", 16'hC123, 16'h0008, 1'b1);
        chk_bub("stall");

        cyc(16'h5555, 16'h000A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_bub++;
        chk_id("nop", 16'h0800, 16'h000A, 1'b0);
        chk_bub("nop");

        cyc(16'h6666, 16'h000C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_bub++;
        chk("flush1.id_instr", id_instr, 16'h0800);
        chk("flush1.id_valid", {15'd0, id_valid}, 16'h0000);
        cyc(16'h7777, 16'h000E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_bub++;
        chk("flush2.id_instr", id_instr, 16'h0800);
        chk("flush2.id_valid", {15'd0, id_valid}, 16'h0000);
        cyc(16'h8888, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_bub++;
        chk("flush3.id_instr", id_instr, 16'h0800);
        chk("flush3.id_valid", {15'd0, id_valid}, 16'h0000);
        cyc(16'h9999, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_id("post_flush", 16'h9999, 16'h0012, 1'b1);
        chk_bub("flush");

        for (int i = 1; i <= 16; i++) begin
            cyc(16'hABCD, 16'h0014, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            exp_bub++;
            chk($sformatf("long_stall%0d.stall_err", i), {15'd0, stall_err},
                (i >= 16) ? 16'h0001 : 16'h0000);
        end
        chk("long_stall.id_pc_nxt", id_pc_nxt, 16'h0012);
        chk_bub("long_stall");

        cyc(16'hABCD, 16'h0014, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_id("err_release", 16'hABCD, 16'h0014, 1'b1);
        chk("err_sticky", {15'd0, stall_err}, 16'h0001);

        cyc(16'hBEEF, 16'h0016, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_bub++;
        cyc(16'hBEEF, 16'h0016, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_bub++;
        chk("err_sticky2", {15'd0, stall_err}, 16'h0001);
        chk_bub("mid_stall");

        cyc(16'hBEEF, 16'h0016, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_bub = 0;
        chk_id("mid_rst", 16'h0800, 16'h0000, 1'b0);
        chk("mid_rst.stall_err", {15'd0, stall_err}, 16'h0000);
        chk_bub("mid_rst");

        cyc(16'hD00D, 16'h0018, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_id("after_rst", 16'hD00D, 16'h0018, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
